// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests and exception info flow in,
// the stall vector, flush and redirect flow out to every pipeline register.

package pipe_ctrl_pkg;
    // Bit order from earliest to latest stage: {pc, if, id, ex, mem}
    typedef struct packed {
        logic stall_pc;
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
    } stall_t;
endpackage

interface pipe_ctrl_if;
    logic                  stallreq_if;
    logic                  stallreq_id;
    logic                  stallreq_mem;
    logic                  ex_mdu_start;
    logic                  mem_except;
    logic [31:0]           mem_except_pc;
    pipe_ctrl_pkg::stall_t stall;
    logic                  flush;
    logic [31:0]           flush_pc;
    logic                  in_delayslot_hold;
    logic                  mdu_busy;

    // Controller side: consumes requests, produces stall/flush
    modport master (
        input  stallreq_if, stallreq_id, stallreq_mem, ex_mdu_start,
               mem_except, mem_except_pc,
        output stall, flush, flush_pc, in_delayslot_hold, mdu_busy
    );

    // Pipeline side: raises requests, samples stall/flush
    modport slave (
        output stallreq_if, stallreq_id, stallreq_mem, ex_mdu_start,
               mem_except, mem_except_pc,
        input  stall, flush, flush_pc, in_delayslot_hold, mdu_busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline control: prioritised stall vector, MDU occupancy of EX,
// and a one-cycle flush that is deferred while a data-side access is pending.

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = $clog2(MDU_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,        // active-low, asynchronous
    pipe_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mdu_state_t;

    // The start cycle itself is one stall cycle, so the count covers the rest
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 2);

    mdu_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pend;
    logic [31:0]       r_pend_pc;

    logic              w_fire_pend;
    logic              w_fire_new;
    logic              w_flush;
    logic              w_mdu_req;
    stall_t            w_stall;

    // Flush decision: a latched exception fires first, a new one only when none is held
    always_comb begin
        w_fire_pend = r_pend & ~bus.stallreq_mem;
        w_fire_new  = ~r_pend & bus.mem_except & ~bus.stallreq_mem;
        w_flush     = w_fire_pend | w_fire_new;
    end

    // Stall cascade: each request stalls its own stage and everything upstream
    always_comb begin
        w_mdu_req         = ((r_state == S_IDLE) & bus.ex_mdu_start) | (r_state == S_BUSY);
        w_stall.stall_mem = bus.stallreq_mem;
        w_stall.stall_ex  = w_stall.stall_mem | w_mdu_req;
        w_stall.stall_id  = w_stall.stall_ex  | bus.stallreq_id;
        w_stall.stall_if  = w_stall.stall_id  | bus.stallreq_if;
        w_stall.stall_pc  = w_stall.stall_if;
        if (w_flush) begin
            w_stall = '0;
        end
    end

    // Outputs are forced quiet while reset is held, whatever the requests say
    assign bus.stall             = rst ? w_stall : '0;
    assign bus.flush             = rst & w_flush;
    assign bus.flush_pc          = (rst & w_flush) ? (r_pend ? r_pend_pc : bus.mem_except_pc) : '0;
    assign bus.in_delayslot_hold = rst & w_stall.stall_if & ~w_stall.stall_id & ~w_flush;
    assign bus.mdu_busy          = rst & (r_state == S_BUSY);

    // MDU occupancy FSM; DONE waits for EX to actually advance before re-arming
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (w_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ex_mdu_start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (!w_stall.stall_ex) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Hold an exception seen during a memory wait; the first target wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
        end else if (w_fire_pend) begin
            r_pend <= 1'b0;
        end else if (!r_pend && bus.mem_except && bus.stallreq_mem) begin
            r_pend    <= 1'b1;
            r_pend_pc <= bus.mem_except_pc;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.

module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int M = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.MDU_CYCLES(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Model state: cycles since MDU start (0 none, 1..M-1 counting, M finished)
    int          m_age     = 0;
    bit          m_pend    = 0;
    logic [31:0] m_pend_pc = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(bit s_if, bit s_id, bit s_mem, bit start, bit exc, logic [31:0] pc);
        bus.stallreq_if   = s_if;
        bus.stallreq_id   = s_id;
        bus.stallreq_mem  = s_mem;
        bus.ex_mdu_start  = start;
        bus.mem_except    = exc;
        bus.mem_except_pc = pc;
    endtask

    // Compare DUT against model for the current cycle, then advance the model
    task automatic model_cycle();
        logic [4:0]  e_stall;
        logic [31:0] e_pc;
        bit          fire, mreq, e_hold, e_busy;
        int          n, v;
        if (!rst) begin
            m_age = 0; m_pend = 0; m_pend_pc = '0;
            e_stall = '0; fire = 0; e_pc = '0; e_hold = 0; e_busy = 0;
        end else begin
            fire = m_pend ? !bus.stallreq_mem : (bus.mem_except && !bus.stallreq_mem);
            e_pc = fire ? (m_pend ? m_pend_pc : bus.mem_except_pc) : 32'h0;
            mreq = (m_age == 0 && bus.ex_mdu_start) || (m_age >= 1 && m_age < M);
            n = bus.stallreq_mem ? 5 : mreq ? 4 : bus.stallreq_id ? 3 : bus.stallreq_if ? 2 : 0;
            if (fire) n = 0;
            v = ((1 << n) - 1) << (5 - n);
            e_stall = v[4:0];
            e_hold  = e_stall[3] && !e_stall[2];
            e_busy  = (m_age >= 1 && m_age < M);
            if (fire) m_age = 0;
            else if (m_age == 0) begin
                if (bus.ex_mdu_start) m_age = 1;
            end else if (m_age < M) m_age++;
            else if (!e_stall[1]) m_age = 0;
            if (m_pend && !bus.stallreq_mem) m_pend = 0;
            else if (!m_pend && bus.mem_except && bus.stallreq_mem) begin
                m_pend = 1; m_pend_pc = bus.mem_except_pc;
            end
        end
        check("model_stall",    bus.stall,             e_stall);
        check("model_flush",    bus.flush,             fire);
        check("model_flush_pc", bus.flush_pc,          e_pc);
        check("model_hold",     bus.in_delayslot_hold, e_hold);
        check("model_busy",     bus.mdu_busy,          e_busy);
    endtask

    task automatic step(string tag, int k);
        @(negedge clk);
        if (tag != "")
            $display("%s k=%0d stall=%b flush=%b flush_pc=%h hold=%b busy=%b",
                     tag, k, bus.stall, bus.flush, bus.flush_pc, bus.in_delayslot_hold, bus.mdu_busy);
        model_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every request asserted
        rst = 1'b0;
        set_in(1, 1, 1, 1, 1, 32'hFFFF_FFFF);
        #1;
        step("reset", 0);
        check("rst_stall", bus.stall, 5'b00000);
        check("rst_flush", bus.flush, 1'b0);
        check("rst_flush_pc", bus.flush_pc, 32'h0);
        check("rst_hold", bus.in_delayslot_hold, 1'b0);
        check("rst_busy", bus.mdu_busy, 1'b0);
        adv();
        rst = 1'b1;
        set_in(0, 1, 0, 0, 0, 32'h0);
        step("id_only", 0);
        check("id_only_stall", bus.stall, 5'b11100);
        adv();

        // MDU occupancy, then a new op killed by an immediate exception
        for (int k = 0; k <= 5; k++) begin
            set_in(0, 0, 0, 1, 0, 32'h0);
            step("mdu", k);
            check("mdu_stall_ex", bus.stall.stall_ex, (k <= 3 || k == 5));
            check("mdu_busy", bus.mdu_busy, (k >= 1 && k <= 3));
            adv();
        end
        set_in(0, 0, 0, 1, 1, 32'hBFC0_0380);
        step("exc_now", 6);
        check("exc_now_flush", bus.flush, 1'b1);
        check("exc_now_pc", bus.flush_pc, 32'hBFC0_0380);
        check("exc_now_stall", bus.stall, 5'b00000);
        check("exc_now_busy", bus.mdu_busy, 1'b1);
        adv();
        set_in(0, 0, 0, 0, 0, 32'h0);
        step("after_flush", 7);
        check("after_flush_busy", bus.mdu_busy, 1'b0);
        adv();

        // MDU overlapping a memory wait
        for (int k = 0; k <= 8; k++) begin
            set_in(0, 0, (k >= 2 && k <= 6), (k <= 7), 0, 32'h0);
            step("mdu_mem", k);
            if (k <= 7)
                check("mdu_mem_stall", bus.stall,
                      (k <= 1) ? 5'b11110 : (k <= 6) ? 5'b11111 : 5'b00000);
            check("mdu_mem_busy", bus.mdu_busy, (k >= 1 && k <= 3));
            adv();
        end

        // Deferred exception; a later one and the one in the firing cycle are dropped
        for (int k = 0; k <= 4; k++) begin
            case (k)
                0: set_in(0, 0, 1, 0, 1, 32'hBFC0_0200);
                1: set_in(0, 0, 1, 0, 1, 32'h8000_0180);
                2: set_in(0, 0, 1, 0, 0, 32'h0);
                3: set_in(0, 0, 0, 0, 1, 32'h8000_0180);
                default: set_in(0, 0, 0, 0, 0, 32'h0);
            endcase
            step("defer", k);
            check("defer_flush", bus.flush, (k == 3));
            check("defer_pc", bus.flush_pc, (k == 3) ? 32'hBFC0_0200 : 32'h0);
            check("defer_stall", bus.stall, (k <= 2) ? 5'b11111 : 5'b00000);
            adv();
        end

        // Delay-slot hold
        set_in(1, 0, 0, 0, 0, 32'h0);
        step("hold", 0);
        check("hold_on", bus.in_delayslot_hold, 1'b1);
        check("hold_stall", bus.stall, 5'b11000);
        adv();
        set_in(1, 1, 0, 0, 0, 32'h0);
        step("hold", 1);
        check("hold_off", bus.in_delayslot_hold, 1'b0);
        adv();

        // A pending exception does not survive reset
        set_in(0, 0, 1, 0, 1, 32'hBFC0_0380);
        step("pend_rst", 0);
        adv();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 32'h0);
        step("pend_rst", 1);
        check("pend_rst_flush_low", bus.flush, 1'b0);
        adv();
        rst = 1'b1;
        step("pend_rst", 2);
        check("pend_rst_gone", bus.flush, 1'b0);
        adv();

        // Randomized traffic, occasional async reset pulses
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) != 0);
            set_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40,
                   $urandom_range(0, 99) < 8, $urandom);
            step("", k);
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
